// File: rtl/desc_crdt_gen.sv
// Descriptor-credit generator: per-queue credit accumulators drained round-robin into bounded
// credit messages on a valid/ready port. Optional coalescing under `DESC_CRDT_COALESCE_EN`.
module desc_crdt_gen #(
    parameter int NUM_Q            = 4,
    parameter int QID_WIDTH        = 11,
    parameter int DESC_AVAIL_WIDTH = 8,
    parameter int CRDT_WIDTH       = 16,
    parameter int MAX_CRDT         = 64,
    parameter int COAL_THRESH      = 8,
    parameter int COAL_TIMEOUT     = 32
) (
    input  logic                        user_clk,
    input  logic                        user_reset_n,
    input  logic [QID_WIDTH-1:0]        qid_base,
    input  logic [NUM_Q-1:0]            q_en,
    input  logic [NUM_Q-1:0]            q_clr,
    input  logic                        add_vld,
    input  logic [$clog2(NUM_Q)-1:0]    add_idx,
    input  logic [DESC_AVAIL_WIDTH-1:0] add_val,
    output logic                        crdt_vld,
    input  logic                        crdt_rdy,
    output logic [QID_WIDTH-1:0]        crdt_qid,
    output logic [CRDT_WIDTH-1:0]       crdt_val,
    output logic                        crdt_ovf,
    output logic                        idle
);
    localparam int IDX_W = $clog2(NUM_Q);
    localparam logic [CRDT_WIDTH-1:0] MAX_C = CRDT_WIDTH'(MAX_CRDT);
    localparam logic [CRDT_WIDTH-1:0] SAT_C = '1;

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    state_e                            state_q, state_d;
    logic [IDX_W-1:0]                  last_grant_q, last_grant_d;
    logic [IDX_W-1:0]                  sel_q, sel_d;
    logic [QID_WIDTH-1:0]              qid_q, qid_d;
    logic [CRDT_WIDTH-1:0]             val_q, val_d;
    logic                              ovf_q, ovf_d;

    logic [NUM_Q-1:0][CRDT_WIDTH-1:0]  acc_all;
    logic [NUM_Q-1:0]                  elig;
    logic [NUM_Q-1:0]                  sat_hit;
    logic                              add_ok;
    logic                              gnt_found;
    logic                              take;
    logic [IDX_W-1:0]                  gnt_idx;
    logic [IDX_W-1:0]                  cand;
    logic [CRDT_WIDTH-1:0]             gnt_val;

    assign add_ok = add_vld && q_en[add_idx];
    assign take   = (state_q == ST_IDLE) && gnt_found;

    // Search starts one past the last served queue; the k==NUM_Q step wraps onto it last.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last_grant_q;
        cand      = last_grant_q;
        for (int k = 1; k <= NUM_Q; k++) begin
            cand = last_grant_q + IDX_W'(k);
            if (!gnt_found && elig[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
        gnt_val = (acc_all[gnt_idx] > MAX_C) ? MAX_C : acc_all[gnt_idx];
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        sel_d        = sel_q;
        qid_d        = qid_q;
        val_d        = val_q;
        ovf_d        = ovf_q | (|sat_hit);
        case (state_q)
            ST_IDLE: begin
                if (gnt_found) begin
                    state_d = ST_SEND;
                    sel_d   = gnt_idx;
                    qid_d   = qid_base + QID_WIDTH'(gnt_idx);
                    val_d   = gnt_val;
                end
            end
            ST_SEND: begin
                // Payload is frozen until accepted, regardless of clears or disables.
                if (crdt_rdy) begin
                    state_d      = ST_IDLE;
                    last_grant_d = sel_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_Q - 1);
            sel_q        <= '0;
            qid_q        <= '0;
            val_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            sel_q        <= sel_d;
            qid_q        <= qid_d;
            val_q        <= val_d;
            ovf_q        <= ovf_d;
        end
    end

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        logic [CRDT_WIDTH-1:0] acc_q, acc_d;
        logic [CRDT_WIDTH-1:0] base;
        logic [CRDT_WIDTH:0]   sum;
        logic                  hit;
        logic                  granted;

        // Grant debit and a same-cycle add combine; clear overrides both.
        always_comb begin
            hit        = add_ok && (add_idx == IDX_W'(g));
            granted    = take && (gnt_idx == IDX_W'(g));
            base       = granted ? (acc_q - gnt_val) : acc_q;
            sum        = {1'b0, base} + (CRDT_WIDTH+1)'(add_val);
            acc_d      = base;
            sat_hit[g] = 1'b0;
            if (q_clr[g]) begin
                acc_d = '0;
            end else if (hit) begin
                if (sum[CRDT_WIDTH]) begin
                    acc_d      = SAT_C;
                    sat_hit[g] = 1'b1;
                end else begin
                    acc_d = sum[CRDT_WIDTH-1:0];
                end
            end
        end

        always_ff @(posedge user_clk or negedge user_reset_n) begin
            if (!user_reset_n) acc_q <= '0;
            else               acc_q <= acc_d;
        end

        assign acc_all[g] = acc_q;

`ifdef DESC_CRDT_COALESCE_EN
        localparam int TMR_W = $clog2(COAL_TIMEOUT + 1);
        logic [TMR_W-1:0] tmr_q, tmr_d;

        always_comb begin
            tmr_d = tmr_q;
            if (hit || granted || q_clr[g])          tmr_d = '0;
            else if (tmr_q != TMR_W'(COAL_TIMEOUT)) tmr_d = tmr_q + 1'b1;
        end

        always_ff @(posedge user_clk or negedge user_reset_n) begin
            if (!user_reset_n) tmr_q <= '0;
            else               tmr_q <= tmr_d;
        end

        assign elig[g] = q_en[g] && ((acc_q >= CRDT_WIDTH'(COAL_THRESH)) ||
                                     ((acc_q != '0) && (tmr_q == TMR_W'(COAL_TIMEOUT))));
`else
        assign elig[g] = q_en[g] && (acc_q != '0);
`endif
    end

`ifndef DESC_CRDT_COALESCE_EN
    localparam int coal_unused = COAL_THRESH + COAL_TIMEOUT;
`endif

    assign crdt_vld = (state_q == ST_SEND);
    assign crdt_qid = qid_q;
    assign crdt_val = val_q;
    assign crdt_ovf = ovf_q;
    assign idle     = (state_q == ST_IDLE) && (acc_all == '0);

endmodule

// File: tb/tb_desc_crdt_gen.sv
// Directed bench for desc_crdt_gen (default build): latency, splitting, stall stability,
// clear handling, saturation, disable and asynchronous reset behaviour.
module tb_desc_crdt_gen;
    logic        user_clk = 1'b0;
    logic        user_reset_n;
    logic [10:0] qid_base;
    logic [3:0]  q_en;
    logic [3:0]  q_clr;
    logic        add_vld;
    logic [1:0]  add_idx;
    logic [7:0]  add_val;
    logic        crdt_vld;
    logic        crdt_rdy;
    logic [10:0] crdt_qid;
    logic [15:0] crdt_val;
    logic        crdt_ovf;
    logic        idle;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int mq_qid[$];
    int mq_val[$];
    int mq_cyc[$];

    desc_crdt_gen dut (
        .user_clk     (user_clk),
        .user_reset_n (user_reset_n),
        .qid_base     (qid_base),
        .q_en         (q_en),
        .q_clr        (q_clr),
        .add_vld      (add_vld),
        .add_idx      (add_idx),
        .add_val      (add_val),
        .crdt_vld     (crdt_vld),
        .crdt_rdy     (crdt_rdy),
        .crdt_qid     (crdt_qid),
        .crdt_val     (crdt_val),
        .crdt_ovf     (crdt_ovf),
        .idle         (idle)
    );

    always #5 user_clk = ~user_clk;

    // Collect every accepted message mid-cycle.
    always @(negedge user_clk) begin
        cyc++;
        if (user_reset_n && crdt_vld && crdt_rdy) begin
            mq_qid.push_back(int'(crdt_qid));
            mq_val.push_back(int'(crdt_val));
            mq_cyc.push_back(cyc);
        end
    end

    task automatic step;
        @(posedge user_clk);
        #1;
    endtask

    task automatic flush_msgs;
        mq_qid.delete();
        mq_val.delete();
        mq_cyc.delete();
    endtask

    task automatic do_reset;
        user_reset_n = 1'b0;
        qid_base = 11'd100;
        q_en     = 4'hF;
        q_clr    = 4'h0;
        add_vld  = 1'b0;
        add_idx  = 2'd0;
        add_val  = 8'd0;
        crdt_rdy = 1'b1;
        step;
        step;
        user_reset_n = 1'b1;
        step;
        flush_msgs;
    endtask

    task automatic wait_msgs(input int n, input int budget);
        int k = 0;
        while (mq_qid.size() < n && k < budget) begin
            step;
            k++;
        end
        repeat (6) step;
    endtask

    task automatic test_reset;
        do_reset;
        checks += 5;
        if (crdt_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", crdt_vld); end
        if (crdt_qid !== 11'd0) begin errors++; $display("FAIL reset_qid got %0d want 0", crdt_qid); end
        if (crdt_val !== 16'd0) begin errors++; $display("FAIL reset_val got %0d want 0", crdt_val); end
        if (crdt_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", crdt_ovf); end
        if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b want 1", idle); end
    endtask

    task automatic test_single;
        do_reset;
        add_vld = 1'b1; add_idx = 2'd0; add_val = 8'd5;
        step;
        add_vld = 1'b0;
        checks += 2;
        if (crdt_vld !== 1'b0) begin errors++; $display("FAIL single_n1_vld got %b want 0", crdt_vld); end
        if (idle !== 1'b0) begin errors++; $display("FAIL single_n1_idle got %b want 0", idle); end
        step;
        checks += 3;
        if (crdt_vld !== 1'b1) begin errors++; $display("FAIL single_n2_vld got %b want 1", crdt_vld); end
        if (crdt_qid !== 11'd100) begin errors++; $display("FAIL single_qid got %0d want 100", crdt_qid); end
        if (crdt_val !== 16'd5) begin errors++; $display("FAIL single_val got %0d want 5", crdt_val); end
        step;
        checks += 3;
        if (crdt_vld !== 1'b0) begin errors++; $display("FAIL single_after_vld got %b want 0", crdt_vld); end
        if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b want 1", idle); end
        if (mq_qid.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", mq_qid.size()); end
    endtask

    task automatic test_back_to_back;
        int exp_val[4] = '{64, 64, 64, 8};
        do_reset;
        add_vld = 1'b1; add_idx = 2'd1; add_val = 8'd200;
        step;
        add_vld = 1'b0;
        wait_msgs(4, 40);
        checks++;
        if (mq_qid.size() != 4) begin
            errors++; $display("FAIL split_count got %0d want 4", mq_qid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (mq_val[i] != exp_val[i]) begin errors++; $display("FAIL split_val[%0d] got %0d want %0d", i, mq_val[i], exp_val[i]); end
                if (mq_qid[i] != 101) begin errors++; $display("FAIL split_qid[%0d] got %0d want 101", i, mq_qid[i]); end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (mq_cyc[i] - mq_cyc[i-1] != 2) begin
                    errors++; $display("FAIL split_gap[%0d] got %0d want 2", i, mq_cyc[i] - mq_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        do_reset;
        crdt_rdy = 1'b0;
        for (int q = 0; q < 4; q++) begin
            add_vld = 1'b1; add_idx = 2'(q); add_val = 8'd3;
            step;
        end
        add_vld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (crdt_vld !== 1'b1 || crdt_qid !== 11'd100 || crdt_val !== 16'd3) begin
                errors++;
                $display("FAIL stall_hold[%0d] got vld=%b qid=%0d val=%0d want 1/100/3", c, crdt_vld, crdt_qid, crdt_val);
            end
            step;
        end
        crdt_rdy = 1'b1;
        wait_msgs(4, 30);
        checks++;
        if (mq_qid.size() != 4) begin
            errors++; $display("FAIL stall_count got %0d want 4", mq_qid.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (mq_qid[i] != 100 + i || mq_val[i] != 3) begin
                    errors++; $display("FAIL rr_order[%0d] got qid=%0d val=%0d want %0d/3", i, mq_qid[i], mq_val[i], 100 + i);
                end
            end
        end
    endtask

    task automatic test_clear;
        do_reset;
        crdt_rdy = 1'b0;
        add_vld = 1'b1; add_idx = 2'd2; add_val = 8'd100;
        step;
        add_vld = 1'b0;
        step;
        checks++;
        if (crdt_vld !== 1'b1 || crdt_qid !== 11'd102 || crdt_val !== 16'd64) begin
            errors++; $display("FAIL clr_send got vld=%b qid=%0d val=%0d want 1/102/64", crdt_vld, crdt_qid, crdt_val);
        end
        q_clr = 4'b0100;
        step;
        q_clr = 4'b0000;
        checks++;
        if (crdt_vld !== 1'b1 || crdt_val !== 16'd64) begin
            errors++; $display("FAIL clr_inflight got vld=%b val=%0d want 1/64", crdt_vld, crdt_val);
        end
        crdt_rdy = 1'b1;
        wait_msgs(2, 12);
        checks += 2;
        if (mq_qid.size() != 1) begin errors++; $display("FAIL clr_count got %0d want 1", mq_qid.size()); end
        if (idle !== 1'b1) begin errors++; $display("FAIL clr_idle got %b want 1", idle); end
        q_clr = 4'b0100;
        add_vld = 1'b1; add_idx = 2'd2; add_val = 8'd7;
        step;
        q_clr = 4'b0000;
        add_vld = 1'b0;
        checks++;
        if (idle !== 1'b1) begin errors++; $display("FAIL clr_add_same got idle=%b want 1", idle); end
        repeat (5) step;
        checks++;
        if (mq_qid.size() != 1) begin errors++; $display("FAIL clr_add_msgs got %0d want 1", mq_qid.size()); end
    endtask

    task automatic test_saturation;
        int sum = 0;
        do_reset;
        crdt_rdy = 1'b0;
        add_vld = 1'b1; add_idx = 2'd3; add_val = 8'd255;
        repeat (257) step;
        checks++;
        if (crdt_ovf !== 1'b0) begin errors++; $display("FAIL sat_pre_ovf got %b want 0", crdt_ovf); end
        step;
        checks++;
        if (crdt_ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", crdt_ovf); end
        repeat (2) step;
        add_vld = 1'b0;
        crdt_rdy = 1'b1;
        wait_msgs(1025, 2400);
        foreach (mq_val[i]) sum += mq_val[i];
        checks += 4;
        if (mq_val.size() != 1025) begin errors++; $display("FAIL sat_count got %0d want 1025", mq_val.size()); end
        if (sum != 65599) begin errors++; $display("FAIL sat_sum got %0d want 65599", sum); end
        if (crdt_ovf !== 1'b1) begin errors++; $display("FAIL sat_sticky got %b want 1", crdt_ovf); end
        if (idle !== 1'b1) begin errors++; $display("FAIL sat_idle got %b want 1", idle); end
        flush_msgs;
        q_en = 4'b0111;
        add_vld = 1'b1; add_idx = 2'd3; add_val = 8'd9;
        repeat (3) step;
        add_vld = 1'b0;
        q_en = 4'hF;
        repeat (6) step;
        checks += 2;
        if (idle !== 1'b1) begin errors++; $display("FAIL dis_idle got %b want 1", idle); end
        if (mq_qid.size() != 0) begin errors++; $display("FAIL dis_msgs got %0d want 0", mq_qid.size()); end
    endtask

    task automatic test_reset_mid_send;
        do_reset;
        crdt_rdy = 1'b0;
        add_vld = 1'b1; add_idx = 2'd0; add_val = 8'd5;
        step;
        add_vld = 1'b0;
        step;
        checks++;
        if (crdt_vld !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got %b want 1", crdt_vld); end
        #2;
        user_reset_n = 1'b0;
        #1;
        checks += 2;
        if (crdt_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_vld got %b want 0", crdt_vld); end
        if (idle !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b want 1", idle); end
        step;
        user_reset_n = 1'b1;
        crdt_rdy = 1'b1;
        repeat (6) step;
        checks++;
        if (mq_qid.size() != 0) begin errors++; $display("FAIL rst_mid_msgs got %0d want 0", mq_qid.size()); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stall;
        test_clear;
        test_saturation;
        test_reset_mid_send;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
